// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state and end-cause status codes.
// STALL reports as STATUS_HALT, told apart by the separate stall_cause bit.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STATUS_NONE    = 2'd0,
    STATUS_EXIT    = 2'd1,
    STATUS_HALT    = 2'd2,
    STATUS_TIMEOUT = 2'd3
  } status_e;

  // A zero reset length still needs one cycle of CPU reset.
  function automatic int unsigned eff_rst_cycles(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/observation bundle between the run controller and its host.
// The host (master) drives start/program-end hints and the CPU PC; the controller reports state.
interface cpu_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             start;
  logic [PC_W-1:0]  halt_pc;
  logic             halt_pc_en;
  logic [PC_W-1:0]  pc;
  logic             exit_syscall;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic [1:0]       status;
  logic             stall_cause;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, halt_pc, halt_pc_en, pc, exit_syscall,
    input  cpu_reset, running, done, status, stall_cause, cycle_count
  );

  modport slave (
    input  start, halt_pc, halt_pc_en, pc, exit_syscall,
    output cpu_reset, running, done, status, stall_cause, cycle_count
  );
endinterface

// File: rtl/cpu_run_ctrl_pc_stall_detect.sv
// Self-loop detector: counts consecutive enabled cycles whose pc equals the previous one.
// The first enabled cycle after clear has no previous pc and never counts.
module pc_stall_detect #(
  parameter int          PC_W        = 32,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            stall_o
);
  localparam int CW = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STALL_LIMIT);

  logic [PC_W-1:0] prev_pc_q;
  logic            prev_vld_q;
  logic [CW-1:0]   eq_cnt_q;
  logic            same_pc;

  assign same_pc = prev_vld_q && (pc_i == prev_pc_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the pc shadow, is reset so nothing from an aborted run leaks out.
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      eq_cnt_q   <= '0;
    end else if (clear_i) begin
      prev_vld_q <= 1'b0;
      eq_cnt_q   <= '0;
    end else if (en_i) begin
      prev_pc_q  <= pc_i;
      prev_vld_q <= 1'b1;
      if (!same_pc)             eq_cnt_q <= '0;
      else if (eq_cnt_q != LIM) eq_cnt_q <= eq_cnt_q + CW'(1);
    end
  end

  // This cycle's equal compare is the STALL_LIMIT-th in a row.
  assign stall_o = (STALL_LIMIT != 0) && en_i && same_pc && (eq_cnt_q >= LIM - CW'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a single-cycle CPU: sequences CPU reset, runs, and latches the
// first end-of-program cause (exit, halt PC, self-loop stall, watchdog) with the cycle count.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int          PC_W        = 32,
  parameter int          CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 50,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  cpu_run_ctrl_if.slave bus
);
  localparam int unsigned RST_EFF = eff_rst_cycles(RST_CYCLES);
  localparam int          RCW     = (RST_EFF < 2) ? 1 : $clog2(RST_EFF + 1);

  state_e           state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
  logic             halt_en_q, halt_en_d;
  status_e          status_q, status_d;
  logic             stall_cause_q, stall_cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic start_ok, in_run, stall;
  logic end_halt, end_timeout;

  assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_run   = (state_q == ST_RUN);

  pc_stall_detect #(.PC_W(PC_W), .STALL_LIMIT(STALL_LIMIT)) u_stall (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (start_ok),
    .en_i    (in_run),
    .pc_i    (bus.pc),
    .stall_o (stall)
  );

  assign end_halt    = halt_en_q && (bus.pc == halt_pc_q);
  assign end_timeout = (TIMEOUT != 0) && ((64'(cnt_q) + 64'd1) == 64'(TIMEOUT));

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latches are inferred.
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    halt_pc_d     = halt_pc_q;
    halt_en_d     = halt_en_q;
    status_d      = status_q;
    stall_cause_d = stall_cause_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d       = ST_RESET;
          rst_cnt_d     = '0;
          halt_pc_d     = bus.halt_pc;
          halt_en_d     = bus.halt_pc_en;
          status_d      = STATUS_NONE;
          stall_cause_d = 1'b0;
          cnt_d         = '0;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RCW'(RST_EFF - 1)) state_d = ST_RUN;
        else                                rst_cnt_d = rst_cnt_q + RCW'(1);
      end
      ST_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        // Priority: exit, halt PC, stall, watchdog.
        if (bus.exit_syscall) begin
          state_d  = ST_DONE;
          status_d = STATUS_EXIT;
        end else if (end_halt) begin
          state_d  = ST_DONE;
          status_d = STATUS_HALT;
        end else if (stall) begin
          state_d       = ST_DONE;
          status_d      = STATUS_HALT;
          stall_cause_d = 1'b1;
        end else if (end_timeout) begin
          state_d  = ST_DONE;
          status_d = STATUS_TIMEOUT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= '0;
      halt_pc_q     <= '0;
      halt_en_q     <= 1'b0;
      status_q      <= STATUS_NONE;
      stall_cause_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      halt_pc_q     <= halt_pc_d;
      halt_en_q     <= halt_en_d;
      status_q      <= status_d;
      stall_cause_q <= stall_cause_d;
      cnt_q         <= cnt_d;
    end
  end

  // Outputs decode registers only; the CPU is held in reset outside RUN.
  assign bus.cpu_reset   = (state_q != ST_RUN);
  assign bus.running     = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.status      = status_q;
  assign bus.stall_cause = stall_cause_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: each program trace is scored by a reference model,
// and a negedge monitor compares the DUT's end report whenever done rises.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int PC_W        = 32;
  localparam int CNT_W       = 32;
  localparam int RST_CYCLES  = 2;
  localparam int TIMEOUT     = 50;
  localparam int STALL_LIMIT = 4;
  localparam int MAXC        = TIMEOUT + 8;

  typedef struct {
    logic [1:0] status;
    logic       stall;
    int         count;
  } exp_t;

  logic clk = 1'b1;
  logic reset;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
    .TIMEOUT(TIMEOUT), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  logic [PC_W-1:0] pc_seq [1:MAXC];
  bit              ex_seq [1:MAXC];
  logic [PC_W-1:0] halt_pc_v;
  bit              halt_en_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: walk the trace cycle by cycle and apply the end rules in priority order.
  function automatic exp_t model();
    exp_t e;
    int   eq;
    eq = 0;
    e.status = 2'd0; e.stall = 1'b0; e.count = 0;
    for (int k = 1; k <= MAXC; k++) begin
      if (k > 1) eq = (pc_seq[k] == pc_seq[k-1]) ? eq + 1 : 0;
      e.count = k;
      if (ex_seq[k])                                   begin e.status = 2'd1; return e; end
      if (halt_en_v && pc_seq[k] == halt_pc_v)         begin e.status = 2'd2; return e; end
      if (STALL_LIMIT != 0 && eq >= STALL_LIMIT)       begin e.status = 2'd2; e.stall = 1'b1; return e; end
      if (TIMEOUT != 0 && k == TIMEOUT)                begin e.status = 2'd3; return e; end
    end
    e.count = 0;
    return e;
  endfunction

  // Monitor: score every rising edge of done against the oldest pending expectation.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {63'd0, bus.done}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_status", {62'd0, bus.status}, {62'd0, e.status});
        check("sb_stall_cause", {63'd0, bus.stall_cause}, {63'd0, e.stall});
        check("sb_cycle_count", 64'(bus.cycle_count), 64'(e.count));
      end
    end
    done_prev <= bus.done;
  end

  task automatic set_linear(input logic [PC_W-1:0] base, input int step);
    for (int k = 1; k <= MAXC; k++) begin
      pc_seq[k] = base + PC_W'(step * (k - 1));
      ex_seq[k] = 1'b0;
    end
  endtask

  task automatic set_random();
    int r;
    int stuck_at;
    stuck_at = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 30) : MAXC + 1;
    for (int k = 1; k <= MAXC; k++) begin
      r = $urandom_range(0, 9);
      if (k == 1)             pc_seq[k] = PC_W'($urandom_range(0, 255) * 4);
      else if (k >= stuck_at) pc_seq[k] = pc_seq[k-1];
      else if (r < 3)         pc_seq[k] = pc_seq[k-1];
      else if (r == 9)        pc_seq[k] = PC_W'($urandom_range(0, 255) * 4);
      else                    pc_seq[k] = pc_seq[k-1] + 32'd4;
      ex_seq[k] = ($urandom_range(0, 59) == 0);
    end
    halt_en_v = ($urandom_range(0, 1) == 1);
    halt_pc_v = ($urandom_range(0, 2) != 0) ? pc_seq[$urandom_range(1, MAXC)]
                                            : PC_W'($urandom);
  endtask

  // Runs one program trace from the "#1 after posedge" phase; abort_at>0 pulls reset mid-run.
  task automatic run_program(input bit inject_start, input int abort_at);
    exp_t e;
    int   rc;
    int   k;
    int   guard;
    e = model();
    if (abort_at == 0) sb_q.push_back(e);

    bus.start      = 1'b1;
    bus.halt_pc    = halt_pc_v;
    bus.halt_pc_en = halt_en_v;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.halt_pc    = ~halt_pc_v;
    bus.halt_pc_en = ~halt_en_v;

    rc = 0;
    guard = 0;
    while (!bus.running && guard < 20) begin
      if (bus.cpu_reset) rc++;
      @(posedge clk); #1;
      guard++;
    end
    check("cpu_reset_cycles", 64'(rc), 64'(RST_CYCLES));
    check("running_after_reset", {63'd0, bus.running}, 64'd1);

    k = 1;
    forever begin
      bus.pc           = pc_seq[k];
      bus.exit_syscall = ex_seq[k];
      bus.start        = inject_start && (k == 3);
      check("run_cycle_count", 64'(bus.cycle_count), 64'(k - 1));
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_cpu_reset", {63'd0, bus.cpu_reset}, 64'd1);
        check("abort_running", {63'd0, bus.running}, 64'd0);
        check("abort_status", {62'd0, bus.status}, 64'd0);
        check("abort_count", 64'(bus.cycle_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.exit_syscall = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) break;
      k++;
      if (k > MAXC) begin
        check("done_within_budget", {63'd0, bus.done}, 64'd1);
        break;
      end
    end
    check("end_cycle", 64'(k), 64'(e.count));

    // Done must be sticky and the report frozen whatever the CPU does next.
    for (int i = 0; i < 2; i++) begin
      bus.pc           = PC_W'($urandom);
      bus.exit_syscall = 1'b1;
      @(posedge clk); #1;
      check("done_sticky", {63'd0, bus.done}, 64'd1);
      check("status_frozen", {62'd0, bus.status}, {62'd0, e.status});
      check("count_frozen", 64'(bus.cycle_count), 64'(e.count));
    end
    bus.exit_syscall = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.halt_pc      = '0;
    bus.halt_pc_en   = 1'b0;
    bus.pc           = '0;
    bus.exit_syscall = 1'b0;

    #2;
    check("rst_cpu_reset", {63'd0, bus.cpu_reset}, 64'd1);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_running", {63'd0, bus.running}, 64'd0);
    check("rst_status", {62'd0, bus.status}, 64'd0);
    check("rst_count", 64'(bus.cycle_count), 64'd0);
    #13 reset = 1'b1;

    // Idle without start: everything holds its reset value.
    for (int i = 0; i < 3; i++) begin
      bus.pc           = PC_W'($urandom);
      bus.exit_syscall = 1'b1;
      @(posedge clk); #1;
      check("idle_cpu_reset", {63'd0, bus.cpu_reset}, 64'd1);
      check("idle_done", {63'd0, bus.done}, 64'd0);
      check("idle_count", 64'(bus.cycle_count), 64'd0);
    end
    bus.exit_syscall = 1'b0;

    // Halt PC reached at the 5th RUN cycle.
    set_linear(32'h0, 4);
    halt_pc_v = 32'h10; halt_en_v = 1'b1;
    run_program(1'b0, 0);

    // Exit and halt PC in the same cycle: exit wins.
    set_linear(32'h0, 4);
    ex_seq[3] = 1'b1;
    halt_pc_v = 32'h8; halt_en_v = 1'b1;
    run_program(1'b0, 0);

    // Incrementing PC with no halt: watchdog at the TIMEOUT-th cycle.
    set_linear(32'h100, 4);
    halt_pc_v = 32'h0; halt_en_v = 1'b0;
    run_program(1'b1, 0);

    // Self-loop at 0x20: reported as HALT with the stall bit.
    set_linear(32'h0, 4);
    for (int k = 3; k <= MAXC; k++) pc_seq[k] = 32'h20;
    halt_pc_v = 32'h1000; halt_en_v = 1'b1;
    run_program(1'b0, 0);

    // Asynchronous reset mid-RUN, then a clean re-run from IDLE.
    set_linear(32'h40, 4);
    halt_en_v = 1'b0;
    run_program(1'b0, 4);
    check("post_abort_done", {63'd0, bus.done}, 64'd0);
    check("post_abort_cpu_reset", {63'd0, bus.cpu_reset}, 64'd1);
    set_linear(32'h40, 4);
    ex_seq[7] = 1'b1;
    run_program(1'b0, 0);

    for (int n = 0; n < 25; n++) begin
      set_random();
      run_program($urandom_range(0, 3) == 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
